// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the miniRISC fetch stage.
//   DEFAULT_RESET_PC        : boot address used when the top is not overridden
//   OPCODE_/FUNC_/IMM_ MSB/LSB : instruction field bit positions
//   fetch_state_t           : fetch FSM state encoding
package instr_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB   = 4;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with its +4 incrementer.
//   clk, rst_n  : clock, asynchronous active-low reset (loads RESET_PC)
//   i_load      : load i_next_pc this cycle
//   i_next_pc   : next PC value (caller guarantees word alignment)
//   o_pc        : current PC
//   o_pc_plus4  : o_pc + 4, wrapping modulo 2^ADDR_W
module instr_fetch_unit_pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_next_pc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus4
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_next_pc;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + ADDR_W'(4);

endmodule

// File: rtl/instr_fetch_unit.sv
// miniRISC fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake, latches the word and exposes its decode fields.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_req/imem_addr         : read request and word address (= pc)
//   imem_ack/imem_rdata        : memory response
//   stall                      : hold the current instruction
//   branch_taken/branch_target : redirect taken when the held instruction retires
//   halt                       : stop after the current instruction
//   instr_valid/instr/pc/pc_plus4 : held instruction and its address
//   opcode/func/imm16          : raw fields of instr
//   halted                     : unit has stopped; only reset restarts it
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic [5:0]         opcode,
    output logic [4:0]         func,
    output logic [15:0]        imm16,
    output logic               halted
);

    // Low address bits are cleared so a misconfigured boot address still
    // produces word-aligned fetches.
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & ~ADDR_W'(3);

    fetch_state_t       r_state;
    logic               r_req;
    logic               r_valid;
    logic               r_halted;
    logic [INSTR_W-1:0] r_instr;

    logic               w_pc_load;
    logic [ADDR_W-1:0]  w_next_pc;
    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_pc_plus4;

    instr_fetch_unit_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC_ALIGNED)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pc_load),
        .i_next_pc  (w_next_pc),
        .o_pc       (w_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    // The PC only moves when the held instruction retires without halting;
    // stall outranks halt, and halt outranks a redirect.
    always_comb begin
        w_pc_load = 1'b0;
        w_next_pc = w_pc_plus4;
        if (r_state == ST_HOLD && !stall && !halt) begin
            w_pc_load = 1'b1;
            if (branch_taken) begin
                w_next_pc = branch_target & ~ADDR_W'(3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_instr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Any ack seen here belongs to a request abandoned by reset.
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_valid <= 1'b0;
                        if (halt) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALTED;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = w_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign pc          = w_pc;
    assign pc_plus4    = w_pc_plus4;
    assign halted      = r_halted;
    assign opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign func        = r_instr[FUNC_MSB:FUNC_LSB];
    assign imm16       = r_instr[IMM_MSB:IMM_LSB];

endmodule
